// File: rtl/adder_measure_sequencer.sv
// Adder delay measurement sequencer: drives operands and tap selects onto an
// instrumented adder, gates its ring oscillator for a timed window and
// accumulates the observed ring edge count over one or more iterations.
module adder_measure_sequencer #(
  parameter int DATA_W = 32
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              active,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] a_cfg,
  input  logic [DATA_W-1:0] b_cfg,
  input  logic [DATA_W-1:0] ext_mask_b_cfg,
  input  logic [DATA_W-1:0] ring_mask_b_cfg,
  input  logic [7:0]        settle_cycles,
  input  logic [15:0]       window_cycles,
  input  logic [3:0]        repeat_count,
  input  logic [DATA_W-1:0] ring_count,
  output logic [DATA_W-1:0] a_input,
  output logic [DATA_W-1:0] b_input,
  output logic [DATA_W-1:0] a_input_ext_bit_b,
  output logic [DATA_W-1:0] a_input_ring_bit_b,
  output logic              run,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              overflow
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SETTLE  = 3'd2,
    RUN     = 3'd3,
    CAPTURE = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t state;
  state_t state_nxt;

  // Configuration captured when a start is accepted
  logic [DATA_W-1:0] a_lat;
  logic [DATA_W-1:0] b_lat;
  logic [DATA_W-1:0] ext_lat;
  logic [DATA_W-1:0] ring_lat;
  logic [7:0]        settle_lat;
  logic [15:0]       window_lat;
  logic [3:0]        repeat_lat;

  logic [DATA_W-1:0] snapshot;
  logic [15:0]       cnt;
  logic [3:0]        iter_cnt;

  // Terminal counts with zero treated as one
  logic [15:0]       settle_last;
  logic [15:0]       window_last;
  logic [3:0]        repeat_last;

  logic              accept;
  logic              kill;
  logic [DATA_W:0]   acc_sum;

  // Modular delta since the snapshot added to the accumulator; the top bit
  // is the carry out of the add.
  function automatic logic [DATA_W:0] acc_add(
    input logic [DATA_W-1:0] acc,
    input logic [DATA_W-1:0] now_cnt,
    input logic [DATA_W-1:0] snap
  );
    logic [DATA_W-1:0] delta;
    delta = now_cnt - snap;
    return {1'b0, acc} + {1'b0, delta};
  endfunction

  // Clamped terminal counts, start/abort qualification and capture sum
  always_comb begin
    settle_last = (settle_lat == 8'd0) ? 16'd0 : ({8'd0, settle_lat} - 16'd1);
    window_last = (window_lat == 16'd0) ? 16'd0 : (window_lat - 16'd1);
    repeat_last = (repeat_lat == 4'd0) ? 4'd0 : (repeat_lat - 4'd1);
    accept      = (state == IDLE) && active && start && !abort;
    kill        = (state != IDLE) && (abort || !active);
    acc_sum     = acc_add(result, ring_count, snapshot);
  end

  // Next-state and status outputs; abort or inactive overrides everything
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    run       = (state == RUN);
    if (kill) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_nxt = LOAD;
        LOAD:    state_nxt = SETTLE;
        SETTLE:  if (cnt == settle_last) state_nxt = RUN;
        RUN:     if (cnt == window_last) state_nxt = CAPTURE;
        CAPTURE: state_nxt = (iter_cnt == repeat_last) ? DONE : SETTLE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register, counters, adder drive and sticky result flags
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state              <= IDLE;
      cnt                <= 16'd0;
      iter_cnt           <= 4'd0;
      done               <= 1'b0;
      result             <= '0;
      overflow           <= 1'b0;
      a_input            <= '0;
      b_input            <= '0;
      a_input_ext_bit_b  <= '1;
      a_input_ring_bit_b <= '1;
    end else begin
      state <= state_nxt;

      // Per-state cycle counter restarts on every state change
      if ((state == IDLE) || (state_nxt != state)) begin
        cnt <= 16'd0;
      end else begin
        cnt <= cnt + 16'd1;
      end

      if (accept) begin
        iter_cnt <= 4'd0;
        done     <= 1'b0;
        result   <= '0;
        overflow <= 1'b0;
      end

      if (kill) begin
        done <= 1'b0;
      end

      if ((state == LOAD) && !kill) begin
        a_input            <= a_lat;
        b_input            <= b_lat;
        a_input_ext_bit_b  <= ext_lat;
        a_input_ring_bit_b <= ring_lat;
      end

      if ((state == CAPTURE) && !kill) begin
        result <= acc_sum[DATA_W-1:0];
        if (acc_sum[DATA_W]) begin
          overflow <= 1'b1;
        end
        if (iter_cnt != repeat_last) begin
          iter_cnt <= iter_cnt + 4'd1;
        end
      end

      if ((state == DONE) && !kill) begin
        done <= 1'b1;
      end
    end
  end

  // Configuration latch and ring counter snapshot (data only, no reset)
  always_ff @(posedge wb_clk_i) begin
    if (accept) begin
      a_lat      <= a_cfg;
      b_lat      <= b_cfg;
      ext_lat    <= ext_mask_b_cfg;
      ring_lat   <= ring_mask_b_cfg;
      settle_lat <= settle_cycles;
      window_lat <= window_cycles;
      repeat_lat <= repeat_count;
    end
    if ((state == SETTLE) && (state_nxt == RUN)) begin
      snapshot <= ring_count;
    end
  end

endmodule
